// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, address decode
// classes and the default location of the 7-segment register.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {STORAGE, SEG, ERR} dec_t;

  localparam logic [31:0] SEG_ADDR_DEFAULT = 32'hFFFF_0000;

  function automatic dec_t decode(input logic [31:0] addr,
                                  input logic [31:0] seg_addr,
                                  input logic [31:0] depth_words);
    if (addr[1:0] != 2'b00) return ERR;
    if (addr == seg_addr) return SEG;
    if ({2'b00, addr[31:2]} < depth_words) return STORAGE;
    return ERR;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a synchronous write port and a registered read port.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one load/store, waits LATENCY
// cycles, then pulses a single-cycle response. Also hosts the 7-seg register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] SEG_ADDR    = SEG_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [6:0]  seg
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_write;
  dec_t        resp_src;
  logic [31:0] arr_rdata;

  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic        eff_write;
  dec_t        eff_dec;
  logic        enter_resp;
  logic        arr_we;

  // With LATENCY=0 RESP is entered on the accept edge itself, so decode and
  // the array ports must see the live request while IDLE, not the capture.
  always_comb begin
    eff_addr   = (state == IDLE) ? req_addr  : cap_addr;
    eff_wdata  = (state == IDLE) ? req_wdata : cap_wdata;
    eff_write  = (state == IDLE) ? req_write : cap_write;
    eff_dec    = decode(eff_addr, SEG_ADDR, 32'(DEPTH_WORDS));
    enter_resp = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                 ((state == WAIT) && (cnt == 3'd0));
    arr_we     = enter_resp && eff_write && (eff_dec == STORAGE);
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(eff_addr[AW+1:2]),
    .wdata(eff_wdata),
    .raddr(eff_addr[AW+1:2]),
    .rdata(arr_rdata)
  );

  assign req_ready = (state == IDLE) && !rst;

  // resp_src of ERR means "return zero" (errors, stores and idle cycles).
  always_comb begin
    resp_rdata = '0;
    case (resp_src)
      STORAGE: resp_rdata = arr_rdata;
      SEG:     resp_rdata = {25'b0, seg};
      default: resp_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_src   <= ERR;
      seg        <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_src   <= ERR;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_write <= req_write;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) state <= RESP;
          else             cnt   <= cnt - 3'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= (eff_dec == ERR);
        resp_src   <= eff_write ? ERR : eff_dec;
        if (eff_write && (eff_dec == SEG)) seg <= eff_wdata[6:0];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance for the main
// function and one LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_write = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic [6:0]  a_seg;

  logic        b_valid = 1'b0, b_write = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic [6:0]  b_seg;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2), .SEG_ADDR(32'hFFFF_0000)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_ready(a_ready),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err), .seg(a_seg));

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0), .SEG_ADDR(32'hFFFF_0000)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err), .seg(b_seg));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One LATENCY=2 transaction on dut_a with per-cycle response timing checks.
  task automatic xact(input string tag, input logic w, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    @(negedge clk);
    chk({tag, " ready"}, {31'b0, a_ready}, 32'd1);
    a_valid = 1'b1; a_write = w; a_addr = addr; a_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk({tag, " early"}, {31'b0, a_rvalid}, 32'd0);
      @(negedge clk);
    end
    chk({tag, " rvalid"}, {31'b0, a_rvalid}, 32'd1);
    rd = a_rdata;
    er = a_err;
    @(negedge clk);
    chk({tag, " pulse end"}, {31'b0, a_rvalid}, 32'd0);
    chk({tag, " rdata idle"}, a_rdata, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    // Reset held from time 0.
    @(negedge clk);
    chk("rst ready", {31'b0, a_ready}, 32'd0);
    chk("rst rvalid", {31'b0, a_rvalid}, 32'd0);
    chk("rst rdata", a_rdata, 32'd0);
    chk("rst err", {31'b0, a_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst ready", {31'b0, a_ready}, 32'd1);
    chk("post-rst seg", {25'b0, a_seg}, 32'd0);
    chk("post-rst b ready", {31'b0, b_ready}, 32'd1);

    xact("st 0x10", 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er);
    chk("st 0x10 err", {31'b0, er}, 32'd0);
    chk("st 0x10 rdata", rd, 32'd0);
    xact("ld 0x10", 1'b0, 32'h10, 32'h0, rd, er);
    chk("ld 0x10 rdata", rd, 32'hDEAD_BEEF);
    chk("ld 0x10 err", {31'b0, er}, 32'd0);

    xact("st seg", 1'b1, 32'hFFFF_0000, 32'h0000_00FF, rd, er);
    chk("st seg err", {31'b0, er}, 32'd0);
    chk("seg value", {25'b0, a_seg}, 32'h7F);
    xact("ld seg", 1'b0, 32'hFFFF_0000, 32'h0, rd, er);
    chk("ld seg rdata", rd, 32'h7F);

    xact("ld 0x11", 1'b0, 32'h11, 32'h0, rd, er);
    chk("ld 0x11 err", {31'b0, er}, 32'd1);
    chk("ld 0x11 rdata", rd, 32'd0);

    xact("st 0x0", 1'b1, 32'h0, 32'h1234_5678, rd, er);
    xact("st 0x100", 1'b1, 32'h100, 32'hAAAA_AAAA, rd, er);
    chk("st 0x100 err", {31'b0, er}, 32'd1);
    chk("st 0x100 rdata", rd, 32'd0);
    chk("seg after err", {25'b0, a_seg}, 32'h7F);
    xact("ld 0x0", 1'b0, 32'h0, 32'h0, rd, er);
    chk("ld 0x0 rdata", rd, 32'h1234_5678);
    chk("ld 0x0 err", {31'b0, er}, 32'd0);

    // Reset in the middle of a store's WAIT phase.
    xact("st 0x20", 1'b1, 32'h20, 32'h0BAD_F00D, rd, er);
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h5555_5555;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst rvalid", {31'b0, a_rvalid}, 32'd0);
    chk("midrst ready", {31'b0, a_ready}, 32'd0);
    chk("midrst seg", {25'b0, a_seg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst no pulse", {31'b0, a_rvalid}, 32'd0);
    end
    xact("ld 0x20", 1'b0, 32'h20, 32'h0, rd, er);
    chk("ld 0x20 rdata", rd, 32'h0BAD_F00D);

    // LATENCY=0: valid held continuously, one accept every two cycles.
    @(negedge clk);
    b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_write = (i < 3);
      b_addr  = 32'(4 * ((i % 3) + 1));
      b_wdata = 32'hC0DE_0000 + 32'(i % 3);
      chk("b idle ready", {31'b0, b_ready}, 32'd1);
      chk("b idle rvalid", {31'b0, b_rvalid}, 32'd0);
      @(negedge clk);
      chk("b resp rvalid", {31'b0, b_rvalid}, 32'd1);
      chk("b resp ready", {31'b0, b_ready}, 32'd0);
      chk("b resp err", {31'b0, b_err}, 32'd0);
      chk("b resp rdata", b_rdata, (i < 3) ? 32'd0 : 32'hC0DE_0000 + 32'(i % 3));
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("b seg", {25'b0, b_seg}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
